// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: opcodes, header layout,
// engine numbering, error codes, FSM states and header validation.
package cmd_pkg;

  // Opcodes carried in header bits [31:24]
  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_DRAW      = 8'h02;
  localparam logic [7:0] OP_SIMD      = 8'h03;
  localparam logic [7:0] OP_SET_COLOR = 8'h10;
  localparam logic [7:0] OP_SET_VP    = 8'h11;

  // Header field positions
  localparam int HDR_OP_LSB    = 24;
  localparam int HDR_LEN_LSB   = 0;
  localparam int FLAG_WAIT_BIT = 16;  // flags[0] of the header word

  // Engine channel numbers
  localparam int ENG_CLEAR  = 0;
  localparam int ENG_RASTER = 1;
  localparam int ENG_SIMD   = 2;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Classifies a header: unknown opcode, wrong length, or acceptable.
  function automatic err_code_e hdr_check(input logic [7:0] op, input logic [15:0] len,
                                          input logic [15:0] max_len);
    err_code_e r;
    r = ERR_NONE;
    case (op)
      OP_CLEAR:     if (len != 16'd0) r = ERR_LEN;
      OP_DRAW:      if (len != 16'd6) r = ERR_LEN;
      OP_SIMD:      if (len == 16'd0 || len > max_len) r = ERR_LEN;
      OP_SET_COLOR: if (len != 16'd1) r = ERR_LEN;
      OP_SET_VP:    if (len != 16'd4) r = ERR_LEN;
      default:      r = ERR_OPCODE;
    endcase
    return r;
  endfunction

  function automatic logic is_engine_op(input logic [7:0] op);
    return (op == OP_CLEAR) || (op == OP_DRAW) || (op == OP_SIMD);
  endfunction

  function automatic int engine_of(input logic [7:0] op);
    int e;
    case (op)
      OP_DRAW: e = ENG_RASTER;
      OP_SIMD: e = ENG_SIMD;
      default: e = ENG_CLEAR;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload capture buffer: a write index plus MAX_PAYLOAD 32-bit words.
// clr_i empties the buffer at the start of a command, wr_i appends a word.
module cmd_payload_buf #(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      wr_i,
  input  logic [31:0]               data_i,
  output logic [3:0]                idx_o,
  output logic [MAX_PAYLOAD*32-1:0] words_o
);

  logic [31:0] words_q [MAX_PAYLOAD];
  logic [3:0]  idx_q;

  // Clear on a new command, otherwise store the incoming word at the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) words_q[i] <= 32'd0;
    end else if (clr_i) begin
      idx_q <= 4'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) words_q[i] <= 32'd0;
    end else if (wr_i) begin
      idx_q <= idx_q + 4'd1;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        if (idx_q == 4'(i)) words_q[i] <= data_i;
      end
    end
  end

  for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_pack
    assign words_o[32*g +: 32] = words_q[g];
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: parses header+payload command words, updates the
// colour/viewport registers and launches engines with the captured payload.
// Handshake: a command word transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready never depends on cmd_valid. Engines get a
// one-cycle eng_start and answer with a one-cycle eng_done.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int N_ENGINES      = 3,
  parameter int MAX_PAYLOAD    = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic [31:0]               cmd_data,
  output logic                      cmd_ready,
  output logic [N_ENGINES-1:0]      eng_start,
  input  logic [N_ENGINES-1:0]      eng_done,
  output logic [N_ENGINES-1:0]      eng_busy,
  output logic [MAX_PAYLOAD*32-1:0] payload,
  output logic [15:0]               payload_len,
  output logic [31:0]               color,
  output logic [15:0]               vp_x0,
  output logic [15:0]               vp_y0,
  output logic [15:0]               vp_x1,
  output logic [15:0]               vp_y1,
  output logic                      err,
  output logic [1:0]                err_code,
  input  logic                      err_clear,
  output logic [2:0]                dbg_state
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [7:0]               op_q, op_d;
  logic                     wait_q, wait_d;
  logic [15:0]              len_q, len_d;
  logic [N_ENGINES-1:0]     sel_q, sel_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [N_ENGINES-1:0]     start_q, start_d;
  logic [N_ENGINES-1:0]     busy_q, busy_d;
  logic [15:0]              plen_q, plen_d;
  logic [31:0]              color_q, color_d;
  logic [15:0]              vp_x0_q, vp_x0_d, vp_y0_q, vp_y0_d;
  logic [15:0]              vp_x1_q, vp_x1_d, vp_y1_q, vp_y1_d;
  logic                     err_q, err_d;
  err_code_e                code_q, code_d;

  logic                     ready_c, xfer, last_word;
  logic                     buf_clr, buf_wr, err_set;
  err_code_e                err_new, hdr_err;
  logic [7:0]               hdr_op;
  logic [15:0]              hdr_len;
  logic [3:0]               buf_idx;
  logic [MAX_PAYLOAD*32-1:0] buf_words;

  cmd_payload_buf #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (buf_clr),
    .wr_i    (buf_wr),
    .data_i  (cmd_data),
    .idx_o   (buf_idx),
    .words_o (buf_words)
  );

  assign hdr_op    = cmd_data[HDR_OP_LSB +: 8];
  assign hdr_len   = cmd_data[HDR_LEN_LSB +: 16];
  assign hdr_err   = hdr_check(hdr_op, hdr_len, 16'(MAX_PAYLOAD));
  assign ready_c   = (state_q == ST_IDLE) || (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
  assign cmd_ready = ready_c & rst_n;
  assign xfer      = cmd_valid & cmd_ready;
  assign last_word = (({12'd0, buf_idx} + 16'd1) == len_q);

  // Next-state, register commits, engine launch and error detection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    len_d    = len_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    start_d  = '0;
    busy_d   = busy_q & ~eng_done;
    plen_d   = plen_q;
    color_d  = color_q;
    vp_x0_d  = vp_x0_q;
    vp_y0_d  = vp_y0_q;
    vp_x1_d  = vp_x1_q;
    vp_y1_d  = vp_y1_q;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
    err_set  = 1'b0;
    err_new  = ERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          op_d   = hdr_op;
          wait_d = cmd_data[FLAG_WAIT_BIT];
          len_d  = hdr_len;
          cnt_d  = hdr_len;
          for (int k = 0; k < N_ENGINES; k++) begin
            sel_d[k] = is_engine_op(hdr_op) && (engine_of(hdr_op) == k);
          end
          if (hdr_err == ERR_NONE) begin
            buf_clr = 1'b1;
            state_d = (hdr_len == 16'd0) ? ST_EXEC : ST_PAYLOAD;
          end else begin
            err_set = 1'b1;
            err_new = hdr_err;
            state_d = (hdr_len != 16'd0) ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          buf_wr = 1'b1;
          if (last_word) begin
            if (op_q == OP_SET_COLOR) color_d = cmd_data;
            if (op_q == OP_SET_VP) begin
              // The first three words are already in the buffer; the fourth is on the bus
              vp_x0_d = buf_words[15:0];
              vp_y0_d = buf_words[47:32];
              vp_x1_d = buf_words[79:64];
              vp_y1_d = cmd_data[15:0];
            end
            state_d = is_engine_op(op_q) ? ST_EXEC : ST_IDLE;
          end
        end
      end
      ST_EXEC: begin
        // A previous no-wait command may still own the engine
        if ((sel_q & busy_q) == '0) begin
          start_d = sel_q;
          busy_d  = busy_d | sel_q;
          plen_d  = len_q;
          cnt_d   = 16'd0;
          state_d = wait_q ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if ((eng_done & sel_q) != '0) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          err_set = 1'b1;
          err_new = ERR_TIMEOUT;
          busy_d  = busy_d & ~sel_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new error outranks a same-cycle clear
    err_d  = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
    code_d = err_set ? err_new : (err_clear ? ERR_NONE : code_q);
  end

  // State and register file; reset discards any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 8'd0;
      wait_q  <= 1'b0;
      len_q   <= 16'd0;
      sel_q   <= '0;
      cnt_q   <= 16'd0;
      start_q <= '0;
      busy_q  <= '0;
      plen_q  <= 16'd0;
      color_q <= 32'd0;
      vp_x0_q <= 16'd0;
      vp_y0_q <= 16'd0;
      vp_x1_q <= 16'hFFFF;
      vp_y1_q <= 16'hFFFF;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      plen_q  <= plen_d;
      color_q <= color_d;
      vp_x0_q <= vp_x0_d;
      vp_y0_q <= vp_y0_d;
      vp_x1_q <= vp_x1_d;
      vp_y1_q <= vp_y1_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign eng_start   = start_q;
  assign eng_busy    = busy_q;
  assign payload     = buf_words;
  assign payload_len = plen_q;
  assign color       = color_q;
  assign vp_x0       = vp_x0_q;
  assign vp_y0       = vp_y0_q;
  assign vp_x1       = vp_x1_q;
  assign vp_y1       = vp_y1_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign dbg_state   = state_q;

endmodule
